// File: rtl/scarv_cop_iencode.sv
`default_nettype none
// ============================================================================
//  Module   : scarv_cop_iencode
//  Purpose  : Encodes a decoded COP instruction record into a 32-bit word.
//             Words are queued in a 2-entry in-order FIFO with valid/ready
//             handshakes on both sides. Accepted legal and illegal records
//             are counted in saturating 16-bit counters.
//  Revision : 1.0 - initial release
// ============================================================================
module scarv_cop_iencode #(
  parameter logic [6:0] OPCODE = 7'b0101011
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  // Decoded-record request side
  input  logic        ie_valid,
  output logic        ie_ready,
  input  logic [3:0]  ie_class,
  input  logic [4:0]  ie_subclass,
  input  logic [2:0]  ie_pw,
  input  logic [3:0]  ie_crd,
  input  logic [3:0]  ie_crs1,
  input  logic [3:0]  ie_crs2,
  input  logic [7:0]  ie_imm8,
  // Encoded-word output side
  output logic        oe_valid,
  input  logic        oe_ready,
  output logic [31:0] oe_encoded,
  output logic        oe_illegal,
  // Statistics
  input  logic        cnt_clear,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_bad
);

  // Instruction class codes; 0 and 10..15 are unencodable.
  localparam logic [3:0] c_CLS_PACKED    = 4'd1;
  localparam logic [3:0] c_CLS_TWIDDLE   = 4'd2;
  localparam logic [3:0] c_CLS_LOADSTORE = 4'd3;
  localparam logic [3:0] c_CLS_RANDOM    = 4'd4;
  localparam logic [3:0] c_CLS_MOVE      = 4'd5;
  localparam logic [3:0] c_CLS_MP        = 4'd6;
  localparam logic [3:0] c_CLS_BITWISE   = 4'd7;
  localparam logic [3:0] c_CLS_AES       = 4'd8;
  localparam logic [3:0] c_CLS_SHA3      = 4'd9;

  // Largest pack width that a packed-arith record may carry.
  localparam logic [2:0]  c_PW_MAX    = 3'b100;
  localparam logic [1:0]  c_FIFO_FULL = 2'd2;
  localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

  // --------------------------------------------------------------------------
  // Encoder
  // --------------------------------------------------------------------------
  logic        w_class_known;
  logic        w_pw_bad;
  logic        w_legal;
  logic        w_use_imm;
  logic [7:0]  w_hi_byte;
  logic [31:0] w_word;

  // Classify the incoming record and assemble its instruction word.
  always_comb begin
    w_class_known = 1'b0;
    w_use_imm     = 1'b0;
    case (ie_class)
      c_CLS_PACKED, c_CLS_LOADSTORE, c_CLS_RANDOM,
      c_CLS_MOVE, c_CLS_MP, c_CLS_AES: begin
        w_class_known = 1'b1;
      end
      c_CLS_TWIDDLE, c_CLS_BITWISE, c_CLS_SHA3: begin
        w_class_known = 1'b1;
        w_use_imm     = 1'b1;
      end
      default: begin
        w_class_known = 1'b0;
      end
    endcase

    // Pack width only matters for packed arithmetic.
    w_pw_bad  = (ie_class == c_CLS_PACKED) && (ie_pw > c_PW_MAX);
    w_legal   = w_class_known && !w_pw_bad;
    w_hi_byte = w_use_imm ? ie_imm8 : {ie_subclass, ie_pw};

    // Unencodable records travel as an all-zero word flagged illegal.
    if (w_legal) begin
      w_word = {w_hi_byte, 1'b0, ie_crs2, ie_crs1, ie_class, ie_crd, OPCODE};
    end else begin
      w_word = 32'h0000_0000;
    end
  end

  // --------------------------------------------------------------------------
  // Two-entry FIFO
  // --------------------------------------------------------------------------
  logic [32:0] fifo_mem_q [0:1];
  logic        wr_ptr_q;
  logic        wr_ptr_d;
  logic        rd_ptr_q;
  logic        rd_ptr_d;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic        w_push;
  logic        w_pop;
  logic [32:0] w_head;

  // Ready depends only on the registered occupancy, never on oe_ready.
  assign ie_ready = (count_q < c_FIFO_FULL);
  assign oe_valid = (count_q != 2'd0);
  assign w_push   = ie_valid && ie_ready;
  assign w_pop    = oe_valid && oe_ready;
  assign w_head   = fifo_mem_q[rd_ptr_q];

  // Outputs read as zero whenever nothing is being presented.
  assign oe_encoded = oe_valid ? w_head[31:0] : 32'h0000_0000;
  assign oe_illegal = oe_valid ? w_head[32]   : 1'b0;

  // Next occupancy and pointer values; one-bit pointers wrap modulo 2.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control state; reset discards anything buffered.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage entries; contents are masked at the output so need no reset.
  for (genvar e = 0; e < 2; e++) begin : g_entry
    // Capture the encoded record into this slot when it is the write target.
    always_ff @(posedge g_clk) begin
      if (w_push && (wr_ptr_q == 1'(e))) begin
        fifo_mem_q[e] <= {!w_legal, w_word};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturating accept counters
  // --------------------------------------------------------------------------
  logic [15:0] cnt_ok_q;
  logic [15:0] cnt_ok_d;
  logic [15:0] cnt_bad_q;
  logic [15:0] cnt_bad_d;

  // Clear wins over a same-cycle increment; increments stop at all-ones.
  always_comb begin
    cnt_ok_d  = cnt_ok_q;
    cnt_bad_d = cnt_bad_q;
    if (cnt_clear) begin
      cnt_ok_d  = 16'h0000;
      cnt_bad_d = 16'h0000;
    end else if (w_push) begin
      if (w_legal && (cnt_ok_q != c_CNT_MAX)) begin
        cnt_ok_d = cnt_ok_q + 16'd1;
      end
      if (!w_legal && (cnt_bad_q != c_CNT_MAX)) begin
        cnt_bad_d = cnt_bad_q + 16'd1;
      end
    end
  end

  // Counter registers, zeroed by reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      cnt_ok_q  <= 16'h0000;
      cnt_bad_q <= 16'h0000;
    end else begin
      cnt_ok_q  <= cnt_ok_d;
      cnt_bad_q <= cnt_bad_d;
    end
  end

  assign cnt_ok  = cnt_ok_q;
  assign cnt_bad = cnt_bad_q;

endmodule
`default_nettype wire

// File: tb/tb_scarv_cop_iencode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scarv_cop_iencode
//  Purpose  : Self-checking bench for scarv_cop_iencode. A negedge monitor
//             keeps a scoreboard of expected words pushed on accept and
//             compared against the FIFO head; directed sequences cover the
//             stall, reset and counter-saturation corners.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scarv_cop_iencode;

  logic        g_clk;
  logic        g_resetn;
  logic        ie_valid;
  logic        ie_ready;
  logic [3:0]  ie_class;
  logic [4:0]  ie_subclass;
  logic [2:0]  ie_pw;
  logic [3:0]  ie_crd;
  logic [3:0]  ie_crs1;
  logic [3:0]  ie_crs2;
  logic [7:0]  ie_imm8;
  logic        oe_valid;
  logic        oe_ready;
  logic [31:0] oe_encoded;
  logic        oe_illegal;
  logic        cnt_clear;
  logic [15:0] cnt_ok;
  logic [15:0] cnt_bad;

  scarv_cop_iencode #(.OPCODE(7'b0101011)) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .ie_valid   (ie_valid),
    .ie_ready   (ie_ready),
    .ie_class   (ie_class),
    .ie_subclass(ie_subclass),
    .ie_pw      (ie_pw),
    .ie_crd     (ie_crd),
    .ie_crs1    (ie_crs1),
    .ie_crs2    (ie_crs2),
    .ie_imm8    (ie_imm8),
    .oe_valid   (oe_valid),
    .oe_ready   (oe_ready),
    .oe_encoded (oe_encoded),
    .oe_illegal (oe_illegal),
    .cnt_clear  (cnt_clear),
    .cnt_ok     (cnt_ok),
    .cnt_bad    (cnt_bad)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [3:0]  cls;
    logic [4:0]  sub;
    logic [2:0]  pw;
    logic [3:0]  crd;
    logic [3:0]  crs1;
    logic [3:0]  crs2;
    logic [7:0]  imm;
    logic [31:0] word;
    logic        ill;
  } vec_t;

  vec_t        tbl [11];
  logic [32:0] sb_q [$];
  logic [31:0] exp_word;
  logic        exp_ill;
  bit          rnd_ready;
  int          errors;
  int          checks;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built straight from the field layout.
  function automatic logic [32:0] model(input vec_t v);
    logic       ok;
    logic [7:0] hi;
    ok = (v.cls >= 4'd1) && (v.cls <= 4'd9) && !((v.cls == 4'd1) && (v.pw > 3'd4));
    hi = (v.cls == 4'd2 || v.cls == 4'd7 || v.cls == 4'd9) ? v.imm : {v.sub, v.pw};
    if (!ok) return {1'b1, 32'h0};
    return {1'b0, hi, 1'b0, v.crs2, v.crs1, v.cls, v.crd, 7'b0101011};
  endfunction

  // Scoreboard monitor: compare head, pop on handshake, push on accept.
  always @(negedge g_clk) begin
    if (!g_resetn) begin
      sb_q.delete();
    end else begin
      chk("valid_vs_occupancy", {63'b0, oe_valid}, {63'b0, sb_q.size() != 0});
      if (oe_valid && sb_q.size() > 0) begin
        chk("fifo_head", {31'b0, oe_illegal, oe_encoded}, {31'b0, sb_q[0]});
        if (oe_ready) void'(sb_q.pop_front());
      end else if (!oe_valid) begin
        chk("idle_outputs_zero", {31'b0, oe_illegal, oe_encoded}, 64'd0);
      end
      if (ie_valid && ie_ready) sb_q.push_back({exp_ill, exp_word});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge g_clk);
      #1;
    end
  endtask

  task automatic send(input vec_t v);
    int n;
    bit acc;
    ie_class    = v.cls;
    ie_subclass = v.sub;
    ie_pw       = v.pw;
    ie_crd      = v.crd;
    ie_crs1     = v.crs1;
    ie_crs2     = v.crs2;
    ie_imm8     = v.imm;
    exp_word    = v.word;
    exp_ill     = v.ill;
    ie_valid    = 1'b1;
    n = 0;
    do begin
      if (rnd_ready) oe_ready = 1'($urandom_range(0, 1));
      acc = ie_ready;
      @(posedge g_clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: record not accepted within %0d cycles", n);
    end
    ie_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    oe_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick(1);
      n++;
    end
    tick(1);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    tick(1);
    g_resetn = 1'b1;
  endtask

  initial begin
    vec_t v;
    logic [32:0] m;
    errors    = 0;
    checks    = 0;
    rnd_ready = 1'b0;
    g_resetn  = 1'b0;
    ie_valid  = 1'b0;
    ie_class  = '0;  ie_subclass = '0; ie_pw = '0;
    ie_crd    = '0;  ie_crs1 = '0;     ie_crs2 = '0; ie_imm8 = '0;
    oe_ready  = 1'b1;
    cnt_clear = 1'b0;
    exp_word  = '0;
    exp_ill   = 1'b0;

    //          cls    sub    pw    crd   crs1  crs2  imm    word           ill
    tbl[0]  = '{4'd1,  5'h03, 3'd2, 4'd2, 4'd3, 4'd4, 8'h00, 32'h1A21_892B, 1'b0};
    tbl[1]  = '{4'd7,  5'h00, 3'd0, 4'd1, 4'd0, 4'd0, 8'hA5, 32'hA500_38AB, 1'b0};
    tbl[2]  = '{4'd0,  5'h03, 3'd2, 4'd2, 4'd3, 4'd4, 8'h11, 32'h0000_0000, 1'b1};
    tbl[3]  = '{4'd1,  5'h03, 3'd7, 4'd2, 4'd3, 4'd4, 8'h00, 32'h0000_0000, 1'b1};
    tbl[4]  = '{4'd1,  5'h1F, 3'd4, 4'hF, 4'hF, 4'hF, 8'h00, 32'hFC7F_8FAB, 1'b0};
    tbl[5]  = '{4'd9,  5'h1F, 3'd7, 4'd0, 4'd1, 4'd2, 8'h3C, 32'h3C10_C82B, 1'b0};
    tbl[6]  = '{4'd10, 5'h01, 3'd1, 4'd1, 4'd1, 4'd1, 8'h01, 32'h0000_0000, 1'b1};
    tbl[7]  = '{4'd15, 5'h1F, 3'd0, 4'hF, 4'hF, 4'hF, 8'hFF, 32'h0000_0000, 1'b1};
    tbl[8]  = '{4'd2,  5'h00, 3'd0, 4'd3, 4'd0, 4'd0, 8'hFF, 32'hFF00_11AB, 1'b0};
    tbl[9]  = '{4'd3,  5'h0A, 3'd5, 4'd0, 4'd0, 4'd0, 8'h00, 32'h5500_182B, 1'b0};
    tbl[10] = '{4'd8,  5'h00, 3'd0, 4'd4, 4'd0, 4'd0, 8'h00, 32'h0000_422B, 1'b0};

    tick(2);
    g_resetn = 1'b1;
    chk("reset_ie_ready", {63'b0, ie_ready}, 64'd1);
    chk("reset_oe_valid", {63'b0, oe_valid}, 64'd0);
    chk("reset_cnt_ok",   {48'b0, cnt_ok},   64'd0);
    chk("reset_cnt_bad",  {48'b0, cnt_bad},  64'd0);

    // First record: presented one cycle after accept.
    send(tbl[0]);
    chk("lat1_valid",   {63'b0, oe_valid},   64'd1);
    chk("lat1_encoded", {32'b0, oe_encoded}, 64'h1A21_892B);
    chk("lat1_illegal", {63'b0, oe_illegal}, 64'd0);
    chk("lat1_cnt_ok",  {48'b0, cnt_ok},     64'd1);

    // Remaining table vectors back-to-back.
    for (int i = 1; i < 11; i++) send(tbl[i]);
    drain();
    chk("table_cnt_ok",  {48'b0, cnt_ok},  64'd7);
    chk("table_cnt_bad", {48'b0, cnt_bad}, 64'd4);

    // Two illegal records in a row.
    do_reset();
    send(tbl[2]);
    send(tbl[3]);
    drain();
    chk("illegal_cnt_bad", {48'b0, cnt_bad}, 64'd2);
    chk("illegal_cnt_ok",  {48'b0, cnt_ok},  64'd0);

    // Backpressure: two fill the FIFO, third waits for the consumer.
    oe_ready = 1'b0;
    send(tbl[4]);
    chk("bp_ready_after1", {63'b0, ie_ready}, 64'd1);
    send(tbl[5]);
    chk("bp_ready_after2", {63'b0, ie_ready}, 64'd0);
    fork
      send(tbl[8]);
      begin
        tick(3);
        chk("bp_ready_held", {63'b0, ie_ready}, 64'd0);
        chk("bp_head_held",  {32'b0, oe_encoded}, 64'hFC7F_8FAB);
        oe_ready = 1'b1;
      end
    join
    drain();

    // Randomised records with a randomly stalling consumer.
    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      v.cls  = 4'($urandom_range(0, 15));
      v.sub  = 5'($urandom);
      v.pw   = 3'($urandom);
      v.crd  = 4'($urandom);
      v.crs1 = 4'($urandom);
      v.crs2 = 4'($urandom);
      v.imm  = 8'($urandom);
      m      = model(v);
      v.word = m[31:0];
      v.ill  = m[32];
      send(v);
    end
    rnd_ready = 1'b0;
    drain();

    // Reset with two words buffered.
    oe_ready = 1'b0;
    send(tbl[1]);
    send(tbl[9]);
    chk("pre_reset_full", {63'b0, ie_ready}, 64'd0);
    do_reset();
    chk("midreset_oe_valid", {63'b0, oe_valid}, 64'd0);
    chk("midreset_ie_ready", {63'b0, ie_ready}, 64'd1);
    chk("midreset_cnt_ok",   {48'b0, cnt_ok},   64'd0);
    chk("midreset_cnt_bad",  {48'b0, cnt_bad},  64'd0);
    oe_ready = 1'b1;

    // Saturation and clear priority.
    for (int i = 0; i < 65535; i++) send(tbl[1]);
    chk("sat_reach_max", {48'b0, cnt_ok}, 64'hFFFF);
    send(tbl[1]);
    send(tbl[1]);
    chk("sat_hold_max", {48'b0, cnt_ok}, 64'hFFFF);
    cnt_clear = 1'b1;
    send(tbl[1]);
    cnt_clear = 1'b0;
    chk("clear_priority", {48'b0, cnt_ok}, 64'd0);
    send(tbl[1]);
    chk("count_after_clear", {48'b0, cnt_ok}, 64'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
